// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit back end.
package usb_tx_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BIT_CNT_W    = $clog2(BYTE_W);
    localparam int unsigned EOP_SE0_BITS = 2;
    localparam int unsigned STUFF_LIMIT  = 6;
    localparam int unsigned ONES_W       = $clog2(STUFF_LIMIT + 1);

    localparam logic [BYTE_W-1:0] SYNC_PATTERN = 8'h80;

    // Line states as {dplus, dminus}
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Byte handshake between the packet source and the serial transmit encoder.
interface usb_tx_encoder_if;

    logic                           tx_valid;
    logic [usb_tx_pkg::BYTE_W-1:0]  tx_data;
    logic                           tx_last;
    logic                           tx_ready;

    modport master (output tx_valid, tx_data, tx_last, input tx_ready);
    modport slave  (input tx_valid, tx_data, tx_last, output tx_ready);

endinterface

// File: rtl/usb_nrzi_stuffer.sv
// NRZI line driver with bit stuffing; a stuffed bit holds pause high for its whole bit period.
module usb_nrzi_stuffer
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic tick,
    input  logic data_bit,
    input  logic force_se0,
    input  logic force_j,
    output logic pause,
    output logic dplus,
    output logic dminus
);

    logic [1:0]        line_q, line_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic              stuff_pending_q, stuff_pending_d;

    // A pending stuff bit takes priority over SE0 so it is sent before EOP
    always_comb begin
        line_d          = line_q;
        ones_cnt_d      = ones_cnt_q;
        stuff_pending_d = stuff_pending_q;
        if (force_j) begin
            ones_cnt_d      = '0;
            stuff_pending_d = 1'b0;
            if (tick) begin
                line_d = J;
            end
        end else if (tick) begin
            if (stuff_pending_q) begin
                line_d          = (line_q == J) ? K : J;
                ones_cnt_d      = '0;
                stuff_pending_d = 1'b0;
            end else if (force_se0) begin
                line_d     = SE0;
                ones_cnt_d = '0;
            end else if (data_bit) begin
                ones_cnt_d = ones_cnt_q + ONES_W'(1);
                if (ones_cnt_q == ONES_W'(STUFF_LIMIT - 1)) begin
                    stuff_pending_d = 1'b1;
                end
            end else begin
                line_d     = (line_q == J) ? K : J;
                ones_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q          <= J;
            ones_cnt_q      <= '0;
            stuff_pending_q <= 1'b0;
        end else begin
            line_q          <= line_d;
            ones_cnt_q      <= ones_cnt_d;
            stuff_pending_q <= stuff_pending_d;
        end
    end

    assign pause  = stuff_pending_q;
    assign dplus  = line_q[1];
    assign dminus = line_q[0];

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed serial transmit encoder: packet FSM, byte shifter and source handshake.
module usb_tx_encoder
    import usb_tx_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    input  logic            bit_tick,
    usb_tx_encoder_if.slave tx,
    output logic            pause,
    output logic            timer_en,
    output logic            timer_clear,
    output logic            dplus_out,
    output logic            dminus_out,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            tx_error
);

    state_t                 state_q, state_d;
    logic [BYTE_W-1:0]      shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   last_q, last_d;
    logic                   active_q, active_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic tick, data_tick, force_se0, force_j, tx_ready_c;

    // The timer restarts during clear, so a coincident strobe is stale
    assign tick      = bit_tick && !clear_q;
    assign data_tick = tick && !pause;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        active_d   = active_q;
        clear_d    = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        tx_ready_c = 1'b0;
        force_se0  = (state_q == EOP_SE0);
        force_j    = (state_q == IDLE) || (state_q == EOP_J);
        unique case (state_q)
            IDLE: begin
                if (tx.tx_valid) begin
                    state_d   = SYNC;
                    shreg_d   = SYNC_PATTERN;
                    bit_cnt_d = '0;
                    last_d    = 1'b0;
                    clear_d   = 1'b1;
                    active_d  = 1'b1;
                end
            end
            SYNC, DATA: begin
                if (data_tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    // Bit 7 goes out now: fetch the next byte or wind down to EOP
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                        if ((state_q == SYNC) || !last_q) begin
                            if (tx.tx_valid) begin
                                state_d    = DATA;
                                shreg_d    = tx.tx_data;
                                last_d     = tx.tx_last;
                                tx_ready_c = 1'b1;
                            end else begin
                                state_d = EOP_SE0;
                                error_d = 1'b1;
                            end
                        end else begin
                            state_d = EOP_SE0;
                        end
                    end
                end
            end
            EOP_SE0: begin
                if (data_tick) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(EOP_SE0_BITS - 1)) begin
                        state_d   = EOP_J;
                        bit_cnt_d = '0;
                    end
                end
            end
            EOP_J: begin
                if (tick) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            active_q  <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            active_q  <= active_d;
            clear_q   <= clear_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    usb_nrzi_stuffer u_stuffer (
        .clk       (clk),
        .n_rst     (n_rst),
        .tick      (tick),
        .data_bit  (shreg_q[0]),
        .force_se0 (force_se0),
        .force_j   (force_j),
        .pause     (pause),
        .dplus     (dplus_out),
        .dminus    (dminus_out)
    );

    assign tx.tx_ready = tx_ready_c;
    assign timer_en    = active_q;
    assign tx_busy     = active_q;
    assign timer_clear = clear_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: per-bit line/pause/ready expectations popped by a monitor.
module tb_usb_tx_encoder;
    import usb_tx_pkg::*;

    logic clk      = 1'b0;
    logic n_rst    = 1'b0;
    logic bit_tick = 1'b0;
    logic pause, timer_en, timer_clear, dplus_out, dminus_out, tx_busy, tx_done, tx_error;

    usb_tx_encoder_if tx_if ();

    usb_tx_encoder dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bit_tick    (bit_tick),
        .tx          (tx_if),
        .pause       (pause),
        .timer_en    (timer_en),
        .timer_clear (timer_clear),
        .dplus_out   (dplus_out),
        .dminus_out  (dminus_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    typedef struct packed {
        logic [1:0] line;
        logic       pause;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   stray_rdy = 0;
    int   bit_idx   = 0;
    int   tcnt      = 0;
    logic tick_on_clear = 1'b0;
    logic fake_tick     = 1'b0;
    logic prev_tick     = 1'b0;
    logic rdy_at_tick   = 1'b0;

    localparam string S_00 = "KJKJKJK*K JKJKJKJK 00J";
    localparam string S_FF = "KJKJKJK*K KKKKk JJJJ 00J";
    localparam string S_2B = "KJKJKJK*K KJJKJJK*K JKKKKKJK 00J";
    localparam string S_UR = "KJKJKJK*K JJKJJKJK 00J";

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic timeout(input string name);
        total_cnt++;
        $display("FAIL timeout_%s: event never arrived, expected within bound", name);
    endtask

    // Symbols: K/J/0 line after a tick, lowercase = pause expected high, '*' = tx_ready on that tick
    task automatic push_exp(input string s);
        logic rdy;
        exp_t e;
        rdy = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "*": rdy = 1'b1;
                "K", "k", "J", "j", "0": begin
                    e.line  = (s[i] == "K" || s[i] == "k") ? K : (s[i] == "0") ? SE0 : J;
                    e.pause = (s[i] == "k" || s[i] == "j");
                    e.rdy   = rdy;
                    rdy     = 1'b0;
                    exp_q.push_back(e);
                end
                default: ;
            endcase
        end
    endtask

    // Bit timer: clears with timer_clear, strobes every 8th enabled cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!timer_en || timer_clear) tcnt = 0;
            else tcnt = (tcnt + 1) % 8;
            fake_tick = tick_on_clear && timer_clear;
            bit_tick  = (timer_en && !timer_clear && tcnt == 7) || fake_tick;
        end
    end

    // Monitor: one expectation consumed per real bit tick
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_tick && n_rst) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_bit%0d: line %b%b with no expected bit", bit_idx, dplus_out, dminus_out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("bit%0d", bit_idx),
                          32'({dplus_out, dminus_out, pause, rdy_at_tick}), 32'(e));
                end
                bit_idx++;
            end
            prev_tick = n_rst && bit_tick && !fake_tick;
            if (prev_tick) rdy_at_tick = tx_if.tx_ready;
            else if (tx_if.tx_ready) stray_rdy++;
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!tx_if.tx_ready && t < 300);
        if (!tx_if.tx_ready) timeout("ready");
    endtask

    task automatic send(input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic last_flag, input string exp, input int exp_err, input logic fake);
        int t;
        push_exp(exp);
        done_cnt      = 0;
        err_cnt       = 0;
        stray_rdy     = 0;
        tick_on_clear = fake;
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = b0;
        tx_if.tx_last  = (n == 1) && last_flag;
        for (int k = 0; k < n; k++) begin
            wait_ready();
            @(posedge clk); #1;
            if (k + 1 < n) begin
                tx_if.tx_data = b1;
                tx_if.tx_last = last_flag;
            end else begin
                tx_if.tx_valid = 1'b0;
                tx_if.tx_last  = 1'b0;
            end
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!tx_done && t < 400);
        if (!tx_done) timeout("done");
        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("error_pulses", 32'(err_cnt), 32'(exp_err));
        check("stray_ready", 32'(stray_rdy), 32'd0);
        check("idle_after", 32'({dplus_out, dminus_out, tx_busy, timer_en, pause}), 32'({J, 3'b000}));
        tick_on_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int ticks;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b0;

        // Reset and idle with no traffic
        repeat (3) @(negedge clk);
        check("in_reset", 32'({dplus_out, dminus_out, tx_if.tx_ready, pause, timer_en, timer_clear,
                               tx_busy, tx_done, tx_error}), 32'({J, 7'b0}));
        #1 n_rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d", i),
                  32'({dplus_out, dminus_out, tx_if.tx_ready, pause, timer_en, timer_clear,
                       tx_busy, tx_done, tx_error}), 32'({J, 7'b0}));
        end

        send(1, 8'h00, 8'h00, 1'b1, S_00, 0, 1'b0);
        send(1, 8'hFF, 8'h00, 1'b1, S_FF, 0, 1'b0);
        send(2, 8'hA5, 8'h3C, 1'b1, S_2B, 0, 1'b1);
        send(1, 8'h12, 8'h00, 1'b0, S_UR, 1, 1'b0);

        // Reset in the middle of DATA, with the line at K
        push_exp("KJKJKJK*K JK");
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_last  = 1'b0;
        ticks = 0;
        t     = 0;
        while (ticks < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (bit_tick && !fake_tick) ticks++;
        end
        if (ticks < 2) timeout("data_ticks");
        repeat (2) @(negedge clk);
        check("pre_reset_line", 32'({dplus_out, dminus_out}), 32'(K));
        check("pre_reset_queue", 32'(exp_q.size()), 32'd0);
        #1 n_rst = 1'b0;
        #1;
        check("reset_line_j", 32'({dplus_out, dminus_out}), 32'(J));
        check("reset_outputs", 32'({tx_busy, timer_en, pause, tx_done, tx_error}), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        #1 n_rst = 1'b1;
        repeat (4) @(negedge clk);

        send(1, 8'h00, 8'h00, 1'b1, S_00, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
Serial back end of the USB full-speed transmit path; sits directly downstream of the bit/byte timer.
- Consumes the timer's per-bit strobe and runs the packet serially: SYNC, then data bytes LSB-first, with bit stuffing and NRZI encoding.
- Drives the D+/D- line outputs and produces EOP.
- Drives the timer's `pause` input during stuffed bits, so the timer's `shift_en` is suppressed for those bit periods.

Parameters:
SYNC_PATTERN, 8'h80, sync byte, sent LSB first
EOP_SE0_BITS, 2, bit periods of SE0 in EOP
STUFF_LIMIT, 6, consecutive transmitted ones that force a stuffed zero

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
bit_tick  in  1  one-cycle strobe per bit period (timer raw 8-count rollover)
tx_valid  in  1  tx_data/tx_last valid
tx_data  in  8  next data byte
tx_last  in  1  qualifies tx_data as the final byte of the packet
tx_ready  out  1  one-cycle pulse: byte consumed this cycle
pause  out  1  to timer: current bit period is a stuffed bit
timer_en  out  1  to timer count_up; high while packet active
timer_clear  out  1  to timer: one-cycle clear at packet start
dplus_out  out  1  D+ line
dminus_out  out  1  D- line
tx_busy  out  1  packet in progress
tx_done  out  1  one-cycle pulse when the trailing J completes
tx_error  out  1  one-cycle pulse on underrun abort

Behaviour:
- Interface: one clock `clk`; `n_rst` is asynchronous and active-low.
- Reset values: dplus_out=1, dminus_out=0 (J); all other outputs 0. Internal state: state=IDLE, ones_cnt=0, stuff_pending=0.
- Reset mid-packet: the line returns to J immediately. No EOP is sent.
- Line encoding:
  - J=(1,0), K=(0,1), SE0=(0,0).
  - NRZI: data 0 toggles J<->K; data 1 holds the line.
  - Line outputs are registered and change only in the cycle after a bit_tick.
- States:
  - IDLE: line J. Waits for tx_valid. On tx_valid: pulse timer_clear for 1 cycle, go to SYNC. Set timer_en=1, tx_busy=1 from the next cycle. tx_data is not consumed in IDLE.
  - SYNC: shift SYNC_PATTERN on 8 bit_ticks. From idle J the line sequence is K J K J K J K K.
  - DATA: shift the loaded byte LSB first, one bit per non-stuff bit_tick.
  - STUFF: a sub-condition of SYNC/DATA, tracked by the stuff_pending flag.
  - EOP_SE0: line SE0 for EOP_SE0_BITS ticks.
  - EOP_J: line J for 1 tick, then go to IDLE. tx_done pulses in the cycle after that tick. timer_en and tx_busy drop the same cycle.
- Byte loading:
  - On the bit_tick that transmits bit 7 of SYNC or of a non-last data byte, sample tx_valid.
  - If tx_valid=1: load tx_data and tx_last, and pulse tx_ready that same cycle.
  - If tx_valid=0 (underrun): go to EOP_SE0 after this bit (and after any pending stuff bit), pulse tx_error.
- After bit 7 of a byte loaded with tx_last=1: go to EOP_SE0, after any pending stuff bit.
- Stuffing:
  - ones_cnt counts consecutive transmitted 1s, including SYNC's final 1 and across byte boundaries.
  - ones_cnt clears on a transmitted 0, on a stuffed bit, and in IDLE.
  - When ones_cnt reaches STUFF_LIMIT, set stuff_pending.
  - While stuff_pending=1: pause=1 (registered, so it is high for the whole bit period). The next bit_tick toggles the line and does not advance the shift register.
  - stuff_pending and pause clear on that tick.
  - A stuff bit due after the last bit of the last byte is sent before EOP.
- Simultaneous events: tx_valid is ignored outside IDLE except at a load tick. bit_tick during timer_clear is ignored.

Decomposition:
- Shared package usb_tx_pkg contains:
  - state enum (IDLE, SYNC, DATA, EOP_SE0, EOP_J)
  - line-state constants J, K, SE0 as 2-bit {dplus, dminus}
  - SYNC_PATTERN
- One sub-module, usb_nrzi_stuffer, holds ones_cnt, stuff_pending, the NRZI line register and pause.
  - Inputs: bit_tick, the data bit, a force-SE0 control and a force-J control.
- The top module holds the FSM, the byte shift register and the handshake.

Test Plan:
1. Reset, no traffic -> dplus/dminus=1/0 held. tx_ready, pause, busy, done, error all 0.
2. One byte 8'h00 with tx_last -> line K J K J K J K K J K J K J K J K, then SE0 SE0 J. tx_ready pulses once at the 8th tick. tx_done pulses once. pause never asserts.
3. One byte 8'hFF with tx_last -> SYNC as above, then K K K K K (stuff, pause high for exactly one bit period) J J J J, then SE0 SE0 J. Total of 9 data-phase bit periods.
4. Bytes 8'hA5, 8'h3C back-to-back with tx_valid held, tx_last on the second -> tx_ready pulses at SYNC bit 7 and at byte-1 bit 7. Decoded NRZI matches the bytes. No stuffing.
5. Byte 8'h12 without tx_last, then tx_valid=0 at its bit-7 tick -> tx_error pulses, EOP SE0 SE0 J follows, and tx_done pulses.
6. n_rst asserted during DATA -> the line is J immediately. A following 8'h00 packet reproduces scenario 2 exactly.
